// File: rtl/piece_move_scheduler.sv
// Move sequencer for the falling tetromino: latches key/gravity requests, queries the
// collision checker one candidate at a time, commits legal moves, locks and respawns pieces.
module piece_move_scheduler #(
  parameter int X_W     = 5,
  parameter int Y_W     = 5,
  parameter int BOARD_H = 20,
  parameter int SPAWN_X = 4,
  parameter int SPAWN_Y = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           key_left,
  input  logic           key_right,
  input  logic           key_down,
  input  logic           key_rot,
  input  logic           grav_tick,
  output logic           chk_req,
  output logic [X_W-1:0] chk_x,
  output logic [Y_W-1:0] chk_y,
  output logic [1:0]     chk_rot,
  input  logic           chk_valid,
  input  logic           chk_ok,
  output logic           lock_req,
  input  logic           lock_done,
  output logic [X_W-1:0] pos_x,
  output logic [Y_W-1:0] pos_y,
  output logic [1:0]     rot,
  output logic           piece_active,
  output logic           move_done,
  output logic           game_over
);

  localparam logic [X_W-1:0] SPAWN_XV = X_W'(SPAWN_X);
  localparam logic [Y_W-1:0] SPAWN_YV = Y_W'(SPAWN_Y);
  localparam logic [Y_W-1:0] Y_BOTTOM = Y_W'(BOARD_H - 1);
  localparam logic [X_W-1:0] X_ZERO   = {X_W{1'b0}};
  localparam logic [X_W-1:0] X_ONE    = X_W'(1);
  localparam logic [Y_W-1:0] Y_ONE    = Y_W'(1);

  typedef enum logic [2:0] {
    S_WAIT_START = 3'd0,
    S_SPAWN      = 3'd1,
    S_IDLE       = 3'd2,
    S_CHECK      = 3'd3,
    S_LOCK       = 3'd4,
    S_OVER       = 3'd5
  } state_t;

  state_t     state_r;
  logic [3:0] pend_r;   // {rot, left, right, down}
  logic       down_r;   // in-flight candidate is a down move
  logic [3:0] set_s;
  logic [3:0] pick_s;

  // Request capture: keys only count while a piece is in play or locking.
  always_comb begin
    set_s = 4'b0000;
    if (state_r == S_IDLE || state_r == S_CHECK || state_r == S_LOCK) begin
      set_s = {key_rot, key_left, key_right, key_down | grav_tick};
    end else begin
      set_s = 4'b0000;
    end
  end

  // Fixed-priority arbitration: rot > left > right > down.
  always_comb begin
    pick_s = 4'b0000;
    if (pend_r[3]) begin
      pick_s = 4'b1000;
    end else if (pend_r[2]) begin
      pick_s = 4'b0100;
    end else if (pend_r[1]) begin
      pick_s = 4'b0010;
    end else if (pend_r[0]) begin
      pick_s = 4'b0001;
    end else begin
      pick_s = 4'b0000;
    end
  end

  // Main sequencer; a new key in the same cycle as a clear survives it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= S_WAIT_START;
      pend_r       <= 4'b0000;
      down_r       <= 1'b0;
      chk_req      <= 1'b0;
      chk_x        <= SPAWN_XV;
      chk_y        <= SPAWN_YV;
      chk_rot      <= 2'd0;
      lock_req     <= 1'b0;
      pos_x        <= SPAWN_XV;
      pos_y        <= SPAWN_YV;
      rot          <= 2'd0;
      piece_active <= 1'b0;
      move_done    <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      move_done <= 1'b0;
      pend_r    <= pend_r | set_s;
      case (state_r)
        S_WAIT_START, S_OVER: begin
          if (start) begin
            state_r   <= S_SPAWN;
            pend_r    <= set_s;
            chk_req   <= 1'b1;
            chk_x     <= SPAWN_XV;
            chk_y     <= SPAWN_YV;
            chk_rot   <= 2'd0;
            down_r    <= 1'b0;
            game_over <= 1'b0;
          end
        end
        S_SPAWN: begin
          if (chk_valid) begin
            chk_req <= 1'b0;
            if (chk_ok) begin
              pos_x        <= chk_x;
              pos_y        <= chk_y;
              rot          <= chk_rot;
              move_done    <= 1'b1;
              piece_active <= 1'b1;
              state_r      <= S_IDLE;
            end else begin
              pend_r       <= set_s;
              piece_active <= 1'b0;
              game_over    <= 1'b1;
              state_r      <= S_OVER;
            end
          end
        end
        S_IDLE: begin
          if (pick_s != 4'b0000) begin
            pend_r <= (pend_r & ~pick_s) | set_s;
            chk_x  <= pos_x;
            chk_y  <= pos_y;
            chk_rot <= rot;
            down_r <= 1'b0;
            case (pick_s)
              4'b1000: begin
                chk_rot <= rot + 2'd1;
                chk_req <= 1'b1;
                state_r <= S_CHECK;
              end
              4'b0100: begin
                // A left move at the wall is discarded without a query.
                if (pos_x != X_ZERO) begin
                  chk_x   <= pos_x - X_ONE;
                  chk_req <= 1'b1;
                  state_r <= S_CHECK;
                end
              end
              4'b0010: begin
                chk_x   <= pos_x + X_ONE;
                chk_req <= 1'b1;
                state_r <= S_CHECK;
              end
              4'b0001: begin
                if (pos_y == Y_BOTTOM) begin
                  lock_req     <= 1'b1;
                  piece_active <= 1'b0;
                  state_r      <= S_LOCK;
                end else begin
                  chk_y   <= pos_y + Y_ONE;
                  down_r  <= 1'b1;
                  chk_req <= 1'b1;
                  state_r <= S_CHECK;
                end
              end
              default: begin
                state_r <= S_IDLE;
              end
            endcase
          end
        end
        S_CHECK: begin
          if (chk_valid) begin
            chk_req <= 1'b0;
            if (chk_ok) begin
              pos_x     <= chk_x;
              pos_y     <= chk_y;
              rot       <= chk_rot;
              move_done <= 1'b1;
              state_r   <= S_IDLE;
            end else if (down_r) begin
              lock_req     <= 1'b1;
              piece_active <= 1'b0;
              state_r      <= S_LOCK;
            end else begin
              state_r <= S_IDLE;
            end
          end
        end
        S_LOCK: begin
          if (lock_done) begin
            lock_req <= 1'b0;
            pend_r   <= set_s;
            chk_req  <= 1'b1;
            chk_x    <= SPAWN_XV;
            chk_y    <= SPAWN_YV;
            chk_rot  <= 2'd0;
            down_r   <= 1'b0;
            state_r  <= S_SPAWN;
          end
        end
        default: begin
          state_r      <= S_WAIT_START;
          pend_r       <= 4'b0000;
          chk_req      <= 1'b0;
          lock_req     <= 1'b0;
          piece_active <= 1'b0;
          game_over    <= 1'b0;
        end
      endcase
    end
  end

endmodule
